// File: rtl/ecu_host_ctrl.sv
// Host-side sweep controller: sends one tagged request to every mesh ECU except (0,0),
// matches tagged responses, and counts matches, mismatches and timeouts.
module ecu_host_ctrl #(
    parameter int X           = 2,
    parameter int Y           = 2,
    parameter int data_width  = 129,
    parameter int x_size      = 1,
    parameter int y_size      = 1,
    parameter int total_width = x_size + y_size + data_width,
    parameter int TIMEOUT     = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   o_valid,
    output logic [total_width-1:0] o_data,
    input  logic                   i_ready,
    input  logic                   i_valid,
    input  logic [total_width-1:0] i_data,
    output logic                   busy,
    output logic                   done,
    output logic [15:0]            resp_count,
    output logic [15:0]            err_count
);

    localparam int PW = x_size + y_size;
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [x_size-1:0] XLast  = x_size'(X - 1);
    localparam logic [y_size-1:0] YLast  = y_size'(Y - 1);
    localparam logic [x_size-1:0] XStart = x_size'((X == 1) ? 0 : 1);
    localparam logic [y_size-1:0] YStart = y_size'((X == 1) ? 1 : 0);
    localparam logic [TW-1:0]     TLast  = TW'(TIMEOUT);

    typedef enum logic [2:0] {StIdle, StSend, StWait, StNext, StDone} state_e;

    state_e                 r_state;
    logic                   r_valid;
    logic [total_width-1:0] r_data;
    logic                   r_busy;
    logic                   r_done;
    logic [15:0]            r_tag;
    logic [15:0]            r_out_tag;
    logic [15:0]            r_resp;
    logic [15:0]            r_err;
    logic [TW-1:0]          r_timer;
    logic [x_size-1:0]      r_x;
    logic [y_size-1:0]      r_y;

    logic [15:0]            w_rsp_tag;
    logic                   w_match;
    logic                   w_timeout;
    logic                   w_last;
    logic [x_size-1:0]      w_tgt_x;
    logic [y_size-1:0]      w_tgt_y;
    logic [total_width-1:0] w_pkt;
    logic [1:0]             w_err_inc;
    logic [15:0]            w_err_next;
    logic                   w_unused;

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] inc);
        logic [16:0] s;
        s = {1'b0, a} + {15'd0, inc};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    assign w_unused = ^i_data;

    always_comb begin
        w_rsp_tag = i_data[PW +: 16];
        w_match   = i_valid && (w_rsp_tag == r_out_tag);
        w_timeout = (r_timer == TLast);
        w_last    = (r_x == XLast) && (r_y == YLast);
        // Target for the next SEND: first target from IDLE, else x-fastest advance
        if (r_state == StIdle) begin
            w_tgt_x = XStart;
            w_tgt_y = YStart;
        end else if (r_x == XLast) begin
            w_tgt_x = '0;
            w_tgt_y = r_y + 1'b1;
        end else begin
            w_tgt_x = r_x + 1'b1;
            w_tgt_y = r_y;
        end
        w_pkt                   = '0;
        w_pkt[x_size-1:0]       = w_tgt_x;
        w_pkt[PW-1:x_size]      = w_tgt_y;
        w_pkt[PW +: 16]         = r_tag;
        if (r_state == StWait) begin
            w_err_inc = {1'b0, i_valid && !w_match} + {1'b0, !w_match && w_timeout};
        end else begin
            w_err_inc = {1'b0, i_valid};
        end
        w_err_next = sat_add(r_err, w_err_inc);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StIdle;
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_tag     <= '0;
            r_out_tag <= '0;
            r_resp    <= '0;
            r_err     <= '0;
            r_timer   <= '0;
            r_x       <= '0;
            r_y       <= '0;
        end else begin
            r_err <= w_err_next;
            unique case (r_state)
                StIdle: begin
                    if (start) begin
                        r_state <= StSend;
                        r_valid <= 1'b1;
                        r_data  <= w_pkt;
                        r_x     <= w_tgt_x;
                        r_y     <= w_tgt_y;
                        r_busy  <= 1'b1;
                        r_resp  <= '0;
                        r_err   <= '0;
                    end
                end
                StSend: begin
                    if (i_ready) begin
                        r_state   <= StWait;
                        r_valid   <= 1'b0;
                        r_out_tag <= r_tag;
                        r_tag     <= r_tag + 16'd1;
                        r_timer   <= '0;
                    end
                end
                StWait: begin
                    if (w_match) begin
                        r_resp  <= sat_add(r_resp, 2'd1);
                        r_state <= StNext;
                    end else if (w_timeout) begin
                        r_state <= StNext;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                StNext: begin
                    if (w_last) begin
                        r_state <= StDone;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= StSend;
                        r_valid <= 1'b1;
                        r_data  <= w_pkt;
                        r_x     <= w_tgt_x;
                        r_y     <= w_tgt_y;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_valid    = r_valid;
    assign o_data     = r_data;
    assign busy       = r_busy;
    assign done       = r_done;
    assign resp_count = r_resp;
    assign err_count  = r_err;

endmodule

// File: tb/tb_ecu_host_ctrl.sv
// Directed bench for ecu_host_ctrl: a cycle table for a clean 2x2 sweep plus
// hand sequences for backpressure, timeout, wrong tag, mid-sweep reset and stray inputs.
module tb_ecu_host_ctrl;

    localparam int TW = 131;

    logic          clk = 1'b0;
    logic          rst, start, i_ready, i_valid;
    logic [TW-1:0] i_data;
    logic          o_valid, busy, done;
    logic [TW-1:0] o_data;
    logic [15:0]   resp_count, err_count;

    int n_checks = 0;
    int n_errors = 0;

    ecu_host_ctrl #(.TIMEOUT(15)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .o_valid    (o_valid),
        .o_data     (o_data),
        .i_ready    (i_ready),
        .i_valid    (i_valid),
        .i_data     (i_data),
        .busy       (busy),
        .done       (done),
        .resp_count (resp_count),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        start, rdy, iv;
        logic [15:0] tag;
        logic        ev, eb, ed;
        logic [15:0] er, ee;
        logic        ex, ey;
        logic [15:0] et;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic s, r, v, input int tg, input logic ev, eb, ed,
                       input int er, ee, input logic ex, ey, input int et);
        vec_t t;
        t.start = s; t.rdy = r; t.iv = v; t.tag = tg[15:0];
        t.ev = ev; t.eb = eb; t.ed = ed; t.er = er[15:0]; t.ee = ee[15:0];
        t.ex = ex; t.ey = ey; t.et = et[15:0];
        vq.push_back(t);
    endtask

    function automatic logic [TW-1:0] mk(input int x, input int y, input int tag);
        logic [TW-1:0] p;
        p = '0;
        p[0] = x[0];
        p[1] = y[0];
        p[17:2] = tag[15:0];
        return p;
    endfunction

    task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic serve(input int ex, input int ey, input int etag, input bit respond,
                         input bit poke_start);
        int n = 0;
        while (!o_valid && n < 20) begin
            step();
            n++;
        end
        chk("req_valid", o_valid, 1);
        chk("req_pkt", o_data, mk(ex, ey, etag));
        i_ready = 1; step(); i_ready = 0;
        chk("hs_drop", o_valid, 0);
        if (poke_start) start = 1;
        step();
        start = 0;
        chk("busy_wait", busy, 1);
        step();
        if (respond) begin
            i_valid = 1;
            i_data  = mk(0, 0, etag);
        end
        step();
        i_valid = 0;
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            if (done) seen = 1;
        end
        chk("done_pulse", seen, 1);
        step();
        chk("done_low", done, 0);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; start = 0; i_ready = 0; i_valid = 0; i_data = '0;
        step(); step();
        rst = 0;
        chk("rst_valid", o_valid, 0);
        chk("rst_data", o_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_resp", resp_count, 0);
        chk("rst_err", err_count, 0);

        // Clean sweep, echo 3 cycles after each handshake
        //  st rdy iv tag | v  b  d  resp err x  y  tag
        add(1, 1, 0, 0,   1, 1, 0, 0, 0,  1, 0, 0);
        add(0, 1, 0, 0,   0, 1, 0, 0, 0,  0, 0, 0);
        add(0, 1, 0, 0,   0, 1, 0, 0, 0,  0, 0, 0);
        add(0, 1, 0, 0,   0, 1, 0, 0, 0,  0, 0, 0);
        add(0, 1, 1, 0,   0, 1, 0, 1, 0,  0, 0, 0);
        add(0, 1, 0, 0,   1, 1, 0, 1, 0,  0, 1, 1);
        add(0, 1, 0, 0,   0, 1, 0, 1, 0,  0, 0, 0);
        add(0, 1, 0, 0,   0, 1, 0, 1, 0,  0, 0, 0);
        add(0, 1, 0, 0,   0, 1, 0, 1, 0,  0, 0, 0);
        add(0, 1, 1, 1,   0, 1, 0, 2, 0,  0, 0, 0);
        add(0, 1, 0, 0,   1, 1, 0, 2, 0,  1, 1, 2);
        add(0, 1, 0, 0,   0, 1, 0, 2, 0,  0, 0, 0);
        add(0, 1, 0, 0,   0, 1, 0, 2, 0,  0, 0, 0);
        add(0, 1, 0, 0,   0, 1, 0, 2, 0,  0, 0, 0);
        add(0, 1, 1, 2,   0, 1, 0, 3, 0,  0, 0, 0);
        add(0, 1, 0, 0,   0, 1, 1, 3, 0,  0, 0, 0);
        add(0, 1, 0, 0,   0, 0, 0, 3, 0,  0, 0, 0);
        foreach (vq[i]) begin
            start = vq[i].start; i_ready = vq[i].rdy; i_valid = vq[i].iv;
            i_data = mk(0, 0, int'(vq[i].tag));
            step();
            chk($sformatf("t%0d_valid", i), o_valid, vq[i].ev);
            chk($sformatf("t%0d_busy", i), busy, vq[i].eb);
            chk($sformatf("t%0d_done", i), done, vq[i].ed);
            chk($sformatf("t%0d_resp", i), resp_count, vq[i].er);
            chk($sformatf("t%0d_err", i), err_count, vq[i].ee);
            if (vq[i].ev)
                chk($sformatf("t%0d_pkt", i), o_data,
                    mk(int'(vq[i].ex), int'(vq[i].ey), int'(vq[i].et)));
        end
        start = 0; i_ready = 0; i_valid = 0;

        // Backpressure: request held for 10 cycles, tag continues from 3
        start = 1; step(); start = 0;
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", o_valid, 1);
            chk("bp_pkt", o_data, mk(1, 0, 3));
            step();
        end
        i_ready = 1; step(); i_ready = 0;
        chk("bp_hs", o_valid, 0);
        step(); step();
        i_valid = 1; i_data = mk(0, 0, 3); step(); i_valid = 0;
        chk("bp_resp", resp_count, 1);

        // Timeout on (0,1)
        step();
        chk("to_pkt", o_data, mk(0, 1, 4));
        i_ready = 1; step(); i_ready = 0;
        for (int i = 0; i < 15; i++) step();
        chk("to_err_before", err_count, 0);
        step();
        chk("to_err_after", err_count, 1);
        chk("to_busy", busy, 1);
        serve(1, 1, 5, 1, 0);
        wait_done();
        chk("to_final_resp", resp_count, 2);
        chk("to_final_err", err_count, 1);

        // Wrong tag then correct one
        start = 1; step(); start = 0;
        chk("wt_pkt", o_data, mk(1, 0, 6));
        i_ready = 1; step(); i_ready = 0;
        i_valid = 1; i_data = mk(0, 0, 16'h1234); step(); i_valid = 0;
        chk("wt_err", err_count, 1);
        chk("wt_resp0", resp_count, 0);
        i_valid = 1; i_data = mk(0, 0, 6); step(); i_valid = 0;
        chk("wt_resp1", resp_count, 1);
        step();
        chk("wt_adv_valid", o_valid, 1);
        chk("wt_adv_pkt", o_data, mk(0, 1, 7));

        // Reset in WAIT, with competing inputs in the same cycle
        i_ready = 1; step(); i_ready = 0;
        rst = 1; start = 1; i_valid = 1; i_ready = 1; i_data = mk(0, 0, 7);
        step();
        rst = 0; start = 0; i_valid = 0; i_ready = 0;
        chk("mr_valid", o_valid, 0);
        chk("mr_data", o_data, 0);
        chk("mr_busy", busy, 0);
        chk("mr_done", done, 0);
        chk("mr_resp", resp_count, 0);
        chk("mr_err", err_count, 0);
        step();
        chk("mr_idle", busy, 0);
        start = 1; step(); start = 0;
        chk("mr_first_pkt", o_data, mk(1, 0, 0));

        // start while busy is ignored; stray i_valid in IDLE counts
        serve(1, 0, 0, 1, 1);
        serve(0, 1, 1, 1, 0);
        serve(1, 1, 2, 1, 0);
        wait_done();
        chk("sb_resp", resp_count, 3);
        chk("sb_err", err_count, 0);
        i_valid = 1; i_data = mk(0, 0, 9); step(); i_valid = 0;
        chk("iv_idle_err", err_count, 1);
        chk("iv_idle_resp", resp_count, 3);
        chk("iv_idle_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ecu_host_ctrl.md
ECU_HOST_CTRL -- requirements
Module: ecu_host_ctrl

Interface
REQ-001 The block SHALL have parameter X, default 2, meaning the mesh column count.
REQ-002 The block SHALL have parameter Y, default 2, meaning the mesh row count.
REQ-003 The block SHALL have parameter data_width, default 129, meaning the payload bits per packet; the minimum is 16.
REQ-004 The block SHALL have parameters x_size and y_size, both default 1, meaning the destination coordinate field widths.
REQ-005 The block SHALL have parameter total_width, default x_size+y_size+data_width, meaning the packet width.
REQ-006 The block SHALL have parameter TIMEOUT, default 255, meaning the number of cycles to wait for a response.
REQ-007 The block SHALL have a single clock, clk (input, 1 bit), and all logic is rising-edge.
REQ-008 The block SHALL have rst (input, 1 bit); reset is synchronous and active-high.
REQ-009 The block SHALL have start (input, 1 bit): a one-cycle pulse that begins a sweep over all ECUs.
REQ-010 The block SHALL have o_valid (output, 1 bit): a request packet is valid toward the NoC.
REQ-011 The block SHALL have o_data (output, total_width): the request packet.
REQ-012 The block SHALL have i_ready (input, 1 bit): the NoC accepts o_data.
REQ-013 The block SHALL have i_valid (input, 1 bit): a response packet is present for one cycle; there is no backpressure.
REQ-014 The block SHALL have i_data (input, total_width): the response packet.
REQ-015 The block SHALL have busy (output, 1 bit): a sweep is in progress.
REQ-016 The block SHALL have done (output, 1 bit): a one-cycle pulse at the end of a sweep.
REQ-017 The block SHALL have resp_count (output, 16 bits): the number of matched responses in the current or last sweep.
REQ-018 The block SHALL have err_count (output, 16 bits): the number of mismatches, timeouts and unexpected responses.

Function
REQ-019 Packet layout SHALL be: bits [x_size-1:0] = destination x; [x_size+y_size-1:x_size] = destination y; upper data_width bits = payload.
REQ-020 Request payload SHALL be: payload[15:0] = 16-bit tag; all other payload bits 0.
REQ-021 The tag SHALL reset to 0 and increment by 1 (wrapping mod 2^16) after every handshake.
REQ-022 The block SHALL have these FSM states: IDLE, SEND, WAIT, NEXT, DONE.
REQ-023 IDLE -> SEND SHALL occur on start; at that point the target is set to (x=1, y=0), or (x=0, y=1) when X=1, and resp_count and err_count clear to 0.
REQ-024 Target iteration SHALL be x-fastest (x increments; on x=X-1, x wraps to 0 and y increments), skipping (0,0); total targets = X*Y-1.
REQ-025 In SEND, o_valid SHALL be 1 and o_data held stable until o_valid&&i_ready; o_valid SHALL NOT drop before the handshake.
REQ-026 On the handshake the FSM SHALL go SEND -> WAIT, o_valid SHALL fall the next cycle, and the timeout counter is cleared.
REQ-027 In WAIT, i_valid with i_data payload[15:0] == outstanding tag SHALL increment resp_count and move to NEXT.
REQ-028 In WAIT, i_valid with a non-matching tag SHALL increment err_count and remain in WAIT; the timer is not reset.
REQ-029 In WAIT, when the timeout counter reaches TIMEOUT without a match, the block SHALL increment err_count and move to NEXT.
REQ-030 If a match and the timeout occur in the same cycle, the match SHALL win (resp_count increments, err_count does not).
REQ-031 NEXT SHALL move to DONE if the last target was served; otherwise it advances the target and moves to SEND; NEXT lasts 1 cycle.
REQ-032 DONE SHALL assert done for 1 cycle and then return to IDLE.
REQ-033 i_valid in IDLE, SEND, NEXT or DONE SHALL increment err_count.
REQ-034 start while busy SHALL be ignored.
REQ-035 busy SHALL be 1 in SEND, WAIT, NEXT and DONE.
REQ-036 Counters SHALL saturate at 16'hFFFF.
REQ-037 Latency from start to the first o_valid SHALL be 1 cycle.

Reset
REQ-038 rst SHALL force, on the next edge: state=IDLE, o_valid=0, o_data=0, busy=0, done=0, tag=0, resp_count=0, err_count=0, timer=0.
REQ-039 rst mid-sweep SHALL abandon the outstanding request with no done pulse; o_valid is allowed to drop without a handshake.
REQ-040 rst SHALL take priority over start, i_valid and i_ready in the same cycle.

Verification
REQ-041 X=2, Y=2, i_ready=1, and each request echoed 3 cycles after it is sent -> o_data destinations (1,0), (0,1), (1,1) with tags 0, 1, 2; done pulses once; resp_count=3, err_count=0.
REQ-042 i_ready held 0 for 10 cycles during SEND -> o_valid stays 1 and o_data stays constant; the handshake occurs on the first cycle i_ready=1.
REQ-043 No response to target (0,1), TIMEOUT=15 -> err_count=1 sixteen cycles after the handshake; the sweep continues; final resp_count=2.
REQ-044 Wrong-tag response followed by the correct one in WAIT -> err_count=1, resp_count increments, and the block advances.
REQ-045 rst asserted in WAIT, then start -> counters reset to 0; the first request after restart has tag 0 and destination (1,0).
REQ-046 i_valid while IDLE, and start while busy -> err_count=1; the sweep is unaffected.
